// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

   typedef enum logic [1:0] {
      EM_RISE = 2'b00,
      EM_FALL = 2'b01,
      EM_BOTH = 2'b10,
      EM_OFF  = 2'b11
   } edge_mode_t;

   localparam int MAX_SYNC = 4;

   // Clamp the requested synchroniser depth into the supported 2..MAX_SYNC range.
   function automatic int sync_len(input int req);
      if (req < 2)
         return 2;
      else if (req > MAX_SYNC)
         return MAX_SYNC;
      else
         return req;
   endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, optional deglitch filter (EDGE_DEGLITCH_EN),
// edge compare, registered pulse, sticky status bit and saturating counter.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int SYNC_N = 2,
   parameter int CNT_W  = 8
`ifdef EDGE_DEGLITCH_EN
   ,
   parameter int FILT_CYC = 3
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             armed,
   input  edge_mode_t       mode,
   input  logic             sts_clr,
   input  logic             cnt_clr,
   output logic             pulse,
   output logic             sticky,
   output logic [CNT_W-1:0] cnt
);

   logic [SYNC_N-1:0] sync_reg;
   logic              lvl;
   logic              prev_reg;
   logic              pulse_reg;
   logic              pulse_next;
   logic              sticky_reg;
   logic [CNT_W-1:0]  cnt_reg;

   always_ff @(posedge clk) begin
      if (rst)
         sync_reg <= '0;
      else
         sync_reg <= {sync_reg[SYNC_N-2:0], d};
   end

`ifdef EDGE_DEGLITCH_EN
   localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

   logic          filt_reg;
   logic [FW-1:0] fcnt_reg;

   // Filtered level follows the synced level only after FILT_CYC consecutive differing cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_reg <= 1'b0;
         fcnt_reg <= '0;
      end else if (sync_reg[SYNC_N-1] == filt_reg) begin
         fcnt_reg <= '0;
      end else if (fcnt_reg == FW'(FILT_CYC - 1)) begin
         filt_reg <= sync_reg[SYNC_N-1];
         fcnt_reg <= '0;
      end else begin
         fcnt_reg <= fcnt_reg + FW'(1);
      end
   end

   assign lvl = filt_reg;
`else
   assign lvl = sync_reg[SYNC_N-1];
`endif

   always_comb begin
      pulse_next = 1'b0;
      unique case (mode)
         EM_RISE: pulse_next = lvl & ~prev_reg;
         EM_FALL: pulse_next = ~lvl & prev_reg;
         EM_BOTH: pulse_next = lvl ^ prev_reg;
         EM_OFF:  pulse_next = 1'b0;
      endcase
      pulse_next = pulse_next & armed;
   end

   // prev tracks the level even while unarmed or disabled, so re-enabling never fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg  <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         prev_reg  <= lvl;
         pulse_reg <= pulse_next;
      end
   end

   // Status and counter react to the visible pulse, so a clear in the pulse cycle loses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         if (pulse_reg)
            sticky_reg <= 1'b1;
         else if (sts_clr)
            sticky_reg <= 1'b0;

         if (cnt_clr)
            cnt_reg <= pulse_reg ? CNT_W'(1) : '0;
         else if (pulse_reg && (cnt_reg != '1))
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign pulse  = pulse_reg;
   assign sticky = sticky_reg;
   assign cnt    = cnt_reg;

endmodule

// File: rtl/multi_edge_detect.sv
// N-channel edge detector top: shared arming counter and mode, CH channel instances.
// Optional deglitch filter enabled by defining EDGE_DEGLITCH_EN.
module multi_edge_detect
   import edge_det_pkg::*;
#(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int FILT_CYC    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       d,
   input  logic [1:0]          mode,
   input  logic [CH-1:0]       sts_clr,
   input  logic [CH-1:0]       cnt_clr,
   output logic [CH-1:0]       pulse,
   output logic [CH-1:0]       sticky,
   output logic [CH*CNT_W-1:0] cnt
);

`ifdef EDGE_DEGLITCH_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   localparam int SYNC_N  = sync_len(SYNC_STAGES);
   // Pulses stay suppressed until prev has loaded a level that went through the whole pipe.
   localparam int ARM_LEN = SYNC_N + 1 + (FILT_ON ? FILT_CYC : 0);
   localparam int ARM_W   = $clog2(ARM_LEN + 1);

   logic [ARM_W-1:0] arm_reg;
   logic             armed;
   edge_mode_t       mode_sel;

   assign armed    = (arm_reg == ARM_W'(ARM_LEN));
   assign mode_sel = edge_mode_t'(mode);

   always_ff @(posedge clk) begin
      if (rst)
         arm_reg <= '0;
      else if (!armed)
         arm_reg <= arm_reg + ARM_W'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_chan
         edge_det_chan #(
            .SYNC_N   (SYNC_N),
            .CNT_W    (CNT_W)
`ifdef EDGE_DEGLITCH_EN
            ,
            .FILT_CYC (FILT_CYC)
`endif
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .d       (d[gi]),
            .armed   (armed),
            .mode    (mode_sel),
            .sts_clr (sts_clr[gi]),
            .cnt_clr (cnt_clr[gi]),
            .pulse   (pulse[gi]),
            .sticky  (sticky[gi]),
            .cnt     (cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: expected pulses queued by stimulus, checked by a monitor.
module tb_multi_edge_detect;
   import edge_det_pkg::*;

   localparam int CH    = 4;
   localparam int SYNC  = 2;
   localparam int CNT_W = 3;
   localparam int FILT  = 3;
`ifdef EDGE_DEGLITCH_EN
   localparam int LAT = SYNC + 1 + FILT;
`else
   localparam int LAT = SYNC + 1;
`endif
   localparam int SP = LAT + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH-1:0]       d;
   logic [1:0]          mode;
   logic [CH-1:0]       sts_clr;
   logic [CH-1:0]       cnt_clr;
   logic [CH-1:0]       pulse;
   logic [CH-1:0]       sticky;
   logic [CH*CNT_W-1:0] cnt;

   typedef struct {
      int            edge_no;
      logic [CH-1:0] mask;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   edge_n = 0;

   multi_edge_detect #(
      .CH          (CH),
      .SYNC_STAGES (SYNC),
      .CNT_W       (CNT_W),
      .FILT_CYC    (FILT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .d       (d),
      .mode    (mode),
      .sts_clr (sts_clr),
      .cnt_clr (cnt_clr),
      .pulse   (pulse),
      .sticky  (sticky),
      .cnt     (cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Monitor: every non-zero pulse vector must match the head of the queue.
   always @(negedge clk) begin
      if (pulse !== '0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: got %b at edge %0d, want none", pulse, edge_n);
         end else begin
            mon_e = exp_q.pop_front();
            if (pulse !== mon_e.mask || edge_n != mon_e.edge_no) begin
               n_bad++;
               $display("FAIL pulse: got %b at edge %0d, want %b at edge %0d",
                        pulse, edge_n, mon_e.mask, mon_e.edge_no);
            end else begin
               $display("ok   pulse: %b at edge %0d", pulse, edge_n);
            end
         end
      end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_n) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_pulse: got none at edge %0d, want %b at edge %0d",
                  edge_n, mon_e.mask, mon_e.edge_no);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one channel level; optionally queue the pulse it should cause.
   task automatic drive(input int ch, input logic val, input bit expect_pulse);
      exp_t e;
      d[ch] = val;
      if (expect_pulse) begin
         e.edge_no = edge_n + LAT;
         e.mask    = '0;
         e.mask[ch] = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int ch);
      return 32'(cnt[ch*CNT_W +: CNT_W]);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; d = '0; mode = EM_RISE; sts_clr = '0; cnt_clr = '0;
      tick(3);
      check("reset_pulse", 32'(pulse), 32'h0);
      check("reset_sticky", 32'(sticky), 32'h0);
      check("reset_cnt", 32'(cnt), 32'h0);
      rst = 1'b0;
      tick(LAT + 1);

      // Single rise on channel 0
      drive(0, 1'b1, 1'b1);
      tick(SP);
      check("t1_sticky", 32'(sticky), 32'h1);
      check("t1_cnt", 32'(cnt), 32'h1);
      drive(0, 1'b0, 1'b0);
      tick(SP);

      // Both-edge mode, then disabled mode
      mode = EM_BOTH;
      for (int i = 0; i < 6; i++) begin
         drive(1, ~d[1], 1'b1);
         tick(SP);
      end
      check("t3_cnt1", cnt_of(1), 32'd6);
      check("t3_sticky", 32'(sticky), 32'h3);
      mode = EM_OFF;
      for (int i = 0; i < 4; i++) begin
         drive(1, ~d[1], 1'b0);
         tick(SP);
      end
      check("t3_cnt1_off", cnt_of(1), 32'd6);
      mode = EM_RISE;
      tick(2);

`ifndef EDGE_DEGLITCH_EN
      // Back-to-back toggles every cycle in both-edge mode
      cnt_clr[1] = 1'b1;
      tick(1);
      cnt_clr = '0;
      check("b2b_clr", cnt_of(1), 32'd0);
      mode = EM_BOTH;
      for (int i = 0; i < 4; i++) begin
         drive(1, ~d[1], 1'b1);
         tick(1);
      end
      tick(SP);
      check("b2b_cnt1", cnt_of(1), 32'd4);
      mode = EM_RISE;
      tick(2);
`endif

      // Saturation and clear-with-pulse on channel 2
      for (int i = 0; i < 9; i++) begin
         drive(2, 1'b1, 1'b1);
         tick(SP);
         drive(2, 1'b0, 1'b0);
         tick(SP);
      end
      check("t4_sat", cnt_of(2), 32'd7);
      drive(2, 1'b1, 1'b1);
      tick(LAT);
      cnt_clr[2] = 1'b1;
      tick(1);
      cnt_clr = '0;
      check("t4_clr_pulse", cnt_of(2), 32'd1);
      drive(2, 1'b0, 1'b0);
      tick(SP);

      // Sticky set beats same-cycle clear on channel 3
      drive(3, 1'b1, 1'b1);
      tick(LAT);
      sts_clr[3] = 1'b1;
      tick(1);
      sts_clr = '0;
      check("t5_set_wins", 32'(sticky[3]), 32'h1);
      tick(2);
      sts_clr[3] = 1'b1;
      tick(1);
      sts_clr = '0;
      check("t5_clear", 32'(sticky), 32'h7);
      drive(3, 1'b0, 1'b0);
      tick(SP);

`ifdef EDGE_DEGLITCH_EN
      // Short glitch is dropped, long pulse passes
      drive(0, 1'b1, 1'b0);
      tick(2);
      drive(0, 1'b0, 1'b0);
      tick(SP);
      drive(0, 1'b1, 1'b1);
      tick(5);
      drive(0, 1'b0, 1'b0);
      tick(SP);
      check("t6_cnt0", cnt_of(0), 32'd2);
`endif

      // Reset mid-operation with inputs held high through it
      rst = 1'b1;
      d = '1;
      tick(1);
      check("mid_rst_sticky", 32'(sticky), 32'h0);
      check("mid_rst_cnt", 32'(cnt), 32'h0);
      check("mid_rst_pulse", 32'(pulse), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(LAT + 8);
      check("t2_cnt", 32'(cnt), 32'h0);
      check("t2_sticky", 32'(sticky), 32'h0);
      d = '0;
      tick(SP);
      drive(0, 1'b1, 1'b1);
      tick(SP);
      check("rearm_cnt", 32'(cnt), 32'h1);
      tick(SP);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
